// File: rtl/hazard_sequencer.sv
// LEGv8 five-stage hazard controller: shadow scoreboard, stall FSM, flushes.
// Optional EX forwarding and load-use-only stalling under `ifdef FORWARDING_EN.
module hazard_sequencer (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ID_VALID,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  ID_RD,
  input  logic        ID_REGWRITE,
  input  logic        ID_MEMREAD,
  input  logic        MEM_BRANCH_TAKEN,
  output logic        PC_WRITE,
  output logic        IFID_WRITE,
  output logic        IDEX_BUBBLE,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        EXMEM_FLUSH,
  output logic [1:0]  FWD_A,
  output logic [1:0]  FWD_B,
  output logic [15:0] STALL_COUNT
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ent_t;

  typedef enum logic {S_RUN, S_STALL} state_t;

  ent_t        r_ex, r_mem, r_wb;
  ent_t        w_id;
  state_t      r_state, w_state_nx;
  logic [1:0]  r_cnt, w_cnt_nx;
  logic [15:0] r_stall_cnt;
  logic [1:0]  w_need;
  logic        w_flush, w_stall;
  logic        w_ex_hit;
  logic [1:0]  w_fwd_a, w_fwd_b;
  logic        w_unused;

  function automatic logic prod(input ent_t e);
    return e.v && e.rw && (e.rd != 5'd31);
  endfunction

  function automatic logic hit(input ent_t e, input logic [4:0] rs,
                               input logic u);
    return prod(e) && u && (rs != 5'd31) && (rs == e.rd);
  endfunction

  assign w_id = '{v: ID_VALID, rd: ID_RD, rw: ID_REGWRITE,
                  mr: ID_MEMREAD, rs1: ID_RS1, rs2: ID_RS2,
                  u1: ID_USES_RS1, u2: ID_USES_RS2};

  assign w_ex_hit = hit(r_ex, ID_RS1, ID_USES_RS1) |
                    hit(r_ex, ID_RS2, ID_USES_RS2);

`ifdef FORWARDING_EN
  always_comb begin
    w_need = 2'd0;
    if (ID_VALID && w_ex_hit && r_ex.mr)
      w_need = 2'd1;
  end

  assign w_fwd_a = hit(r_mem, r_ex.rs1, r_ex.u1) ? 2'b10 :
                   hit(r_wb,  r_ex.rs1, r_ex.u1) ? 2'b01 : 2'b00;
  assign w_fwd_b = hit(r_mem, r_ex.rs2, r_ex.u2) ? 2'b10 :
                   hit(r_wb,  r_ex.rs2, r_ex.u2) ? 2'b01 : 2'b00;
`else
  logic w_mem_hit;
  assign w_mem_hit = hit(r_mem, ID_RS1, ID_USES_RS1) |
                     hit(r_mem, ID_RS2, ID_USES_RS2);

  // WB producers never stall: the regfile writes before it is read.
  always_comb begin
    w_need = 2'd0;
    if (ID_VALID) begin
      if (w_ex_hit)       w_need = 2'd2;
      else if (w_mem_hit) w_need = 2'd1;
    end
  end

  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;
`endif

  assign w_unused = ^{r_ex, r_mem, r_wb};

  assign w_flush = MEM_BRANCH_TAKEN;
  assign w_stall = !w_flush && ((r_state == S_STALL) || (w_need != 2'd0));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (!w_flush && w_need == 2'd2) begin
          w_state_nx = S_STALL;
          w_cnt_nx   = 2'd1;
        end
      end
      S_STALL: begin
        if (w_flush) begin
          w_state_nx = S_RUN;
          w_cnt_nx   = 2'd0;
        end else begin
          w_cnt_nx = r_cnt - 2'd1;
          if (r_cnt <= 2'd1)
            w_state_nx = S_RUN;
        end
      end
      default: begin
        w_state_nx = S_RUN;
        w_cnt_nx   = 2'd0;
      end
    endcase
  end

  always_comb begin
    PC_WRITE    = 1'b1;
    IFID_WRITE  = 1'b1;
    IDEX_BUBBLE = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    FWD_A       = 2'b00;
    FWD_B       = 2'b00;
    if (!RESET) begin
      if (w_flush) begin
        IFID_FLUSH  = 1'b1;
        IDEX_FLUSH  = 1'b1;
        EXMEM_FLUSH = 1'b1;
      end else if (w_stall) begin
        PC_WRITE    = 1'b0;
        IFID_WRITE  = 1'b0;
        IDEX_BUBBLE = 1'b1;
      end
      FWD_A = w_fwd_a;
      FWD_B = w_fwd_b;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb <= r_mem;
      if (w_flush) begin
        r_mem <= '0;
        r_ex  <= '0;
      end else begin
        r_mem <= r_ex;
        r_ex  <= w_stall ? '0 : w_id;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      r_stall_cnt <= 16'd0;
    else if (w_stall && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign STALL_COUNT = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed hazard scenarios
// plus random traffic against a pipeline-queue reference model.
module tb_hazard_sequencer;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        ID_VALID = 1'b0;
  logic [4:0]  ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
  logic        ID_USES_RS1 = 1'b0, ID_USES_RS2 = 1'b0;
  logic        ID_REGWRITE = 1'b0, ID_MEMREAD = 1'b0;
  logic        MEM_BRANCH_TAKEN = 1'b0;
  logic        PC_WRITE, IFID_WRITE, IDEX_BUBBLE;
  logic        IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH;
  logic [1:0]  FWD_A, FWD_B;
  logic [15:0] STALL_COUNT;

  hazard_sequencer dut (
    .CLOCK(CLOCK), .RESET(RESET), .ID_VALID(ID_VALID),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .ID_RD(ID_RD), .ID_REGWRITE(ID_REGWRITE), .ID_MEMREAD(ID_MEMREAD),
    .MEM_BRANCH_TAKEN(MEM_BRANCH_TAKEN),
    .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE),
    .IDEX_BUBBLE(IDEX_BUBBLE), .IFID_FLUSH(IFID_FLUSH),
    .IDEX_FLUSH(IDEX_FLUSH), .EXMEM_FLUSH(EXMEM_FLUSH),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
  } ins_t;

  localparam logic [9:0] RST_OUT = 10'b11_0_000_00_00;

  // Reference model: in-flight instructions, oldest last (EX, MEM, WB).
  ins_t        pipe [3];
  int          stall_left;
  logic [15:0] scnt;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic ins_t mk(bit v, int rd, bit rw, bit mr,
                              int rs1, bit u1, int rs2, bit u2);
    ins_t t;
    t.v = v; t.rd = 5'(rd); t.rw = rw; t.mr = mr;
    t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
    return t;
  endfunction

  function automatic bit reads(ins_t p, int rs, bit u);
    return p.v && p.rw && p.rd != 31 && u && rs != 31 && rs == p.rd;
  endfunction

  function automatic int need_of(ins_t id);
    bit ex_hit, mem_hit;
    if (!id.v) return 0;
    ex_hit  = reads(pipe[0], id.rs1, id.u1) || reads(pipe[0], id.rs2, id.u2);
    mem_hit = reads(pipe[1], id.rs1, id.u1) || reads(pipe[1], id.rs2, id.u2);
`ifdef FORWARDING_EN
    return (ex_hit && pipe[0].mr) ? 1 : 0;
`else
    return ex_hit ? 2 : (mem_hit ? 1 : 0);
`endif
  endfunction

  function automatic bit [1:0] fwd_of(int rs, bit u);
`ifdef FORWARDING_EN
    if (reads(pipe[1], rs, u)) return 2'b10;
    if (reads(pipe[2], rs, u)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [9:0] outs();
    return {PC_WRITE, IFID_WRITE, IDEX_BUBBLE,
            IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, FWD_A, FWD_B};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    stall_left = 0;
    scnt = 16'd0;
  endtask

  task automatic drive(ins_t id, bit br);
    ID_VALID = id.v; ID_RD = id.rd; ID_REGWRITE = id.rw;
    ID_MEMREAD = id.mr; ID_RS1 = id.rs1; ID_USES_RS1 = id.u1;
    ID_RS2 = id.rs2; ID_USES_RS2 = id.u2; MEM_BRANCH_TAKEN = br;
  endtask

  // One clock: drive, check at negedge, advance the model over the next edge.
  task automatic step(input ins_t id, input bit br, input string tag,
                      output bit adv);
    int         need;
    bit         stall;
    logic [9:0] exp_v, got_v;
    @(posedge CLOCK); #1;
    drive(id, br);
    @(negedge CLOCK);
    need  = need_of(id);
    stall = !br && (stall_left > 0 || need > 0);
    exp_v = {!stall, !stall, stall, br, br, br,
             fwd_of(pipe[0].rs1, pipe[0].u1),
             fwd_of(pipe[0].rs2, pipe[0].u2)};
    got_v = outs();
    n_assert++;
    assert (got_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s ctrl got=%b exp=%b", tag, got_v, exp_v);
    end
    n_assert++;
    assert (STALL_COUNT === scnt) else begin
      n_fail++;
      $error("FAIL %s stall_count got=%0d exp=%0d", tag, STALL_COUNT, scnt);
    end
    adv = 1'b0;
    pipe[2] = pipe[1];
    if (br) begin
      stall_left = 0;
      pipe[1] = '0;
      pipe[0] = '0;
    end else if (stall) begin
      stall_left = (stall_left > 0) ? stall_left - 1 : need - 1;
      pipe[1] = pipe[0];
      pipe[0] = '0;
      if (scnt != 16'hFFFF) scnt = scnt + 16'd1;
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = id;
      adv = 1'b1;
    end
  endtask

  // Hold an instruction in ID until the model says it advanced.
  task automatic issue(input ins_t id, input string tag);
    bit adv;
    int tries;
    adv = 1'b0;
    tries = 0;
    while (!adv && tries < 5) begin
      step(id, 1'b0, tag, adv);
      tries++;
    end
    n_assert++;
    assert (adv) else begin
      n_fail++;
      $error("FAIL %s issue got=stuck exp=advance", tag);
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLOCK); #1;
    drive('0, 1'b0);
    RESET = 1'b1;
    @(negedge CLOCK);
    n_assert++;
    assert (outs() === RST_OUT && STALL_COUNT === 16'd0) else begin
      n_fail++;
      $error("FAIL %s reset got=%b/%0d exp=%b/0", tag, outs(),
             STALL_COUNT, RST_OUT);
    end
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    model_reset();
  endtask

  ins_t idle, add_x1, sub_x5, ldur_x2, add_x3, p31, c31, rin;
  bit   adv;
  int   regs [5] = '{0, 1, 2, 3, 31};

  initial begin
    idle    = '0;
    add_x1  = mk(1, 1, 1, 0, 6, 1, 7, 1);
    sub_x5  = mk(1, 5, 1, 0, 1, 1, 1, 1);
    ldur_x2 = mk(1, 2, 1, 1, 9, 1, 0, 0);
    add_x3  = mk(1, 3, 1, 0, 2, 1, 4, 1);
    p31     = mk(1, 31, 1, 0, 8, 1, 9, 1);
    c31     = mk(1, 10, 1, 0, 31, 1, 31, 1);
    model_reset();

    do_reset("rst0");
    step(idle, 1'b0, "idle0", adv);

    // ALU producer then dependent ALU consumer
    issue(add_x1, "add_x1");
    issue(sub_x5, "sub_x5");
    step(idle, 1'b0, "sub_in_ex", adv);
    n_assert++;
`ifdef FORWARDING_EN
    assert ({FWD_A, FWD_B, STALL_COUNT} === {4'b1010, 16'd0}) else begin
`else
    assert ({FWD_A, FWD_B, STALL_COUNT} === {4'b0000, 16'd2}) else begin
`endif
      n_fail++;
      $error("FAIL addsub_fwd_cnt got=%b%b/%0d", FWD_A, FWD_B, STALL_COUNT);
    end

    // Load then dependent use
    do_reset("rst1");
    issue(ldur_x2, "ldur_x2");
    issue(add_x3, "add_x3");
    step(idle, 1'b0, "add_in_ex", adv);
    n_assert++;
`ifdef FORWARDING_EN
    assert ({FWD_A, STALL_COUNT} === {2'b01, 16'd1}) else begin
`else
    assert ({FWD_A, STALL_COUNT} === {2'b00, 16'd2}) else begin
`endif
      n_fail++;
      $error("FAIL loaduse_fwd_cnt got=%b/%0d", FWD_A, STALL_COUNT);
    end

    // XZR is never a real dependency
    do_reset("rst2");
    issue(p31, "p31");
    issue(c31, "c31");
    step(idle, 1'b0, "c31_in_ex", adv);
    n_assert++;
    assert ({FWD_A, FWD_B, STALL_COUNT} === {4'b0000, 16'd0}) else begin
      n_fail++;
      $error("FAIL xzr got=%b%b/%0d exp=0000/0", FWD_A, FWD_B, STALL_COUNT);
    end

    // Branch flush arriving while stalled
    do_reset("rst3");
    issue(add_x1, "fl_add");
    step(sub_x5, 1'b0, "fl_sub", adv);
    step(sub_x5, 1'b1, "fl_branch", adv);
    n_assert++;
    assert ({PC_WRITE, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH} === 4'b1111)
    else begin
      n_fail++;
      $error("FAIL flush_outs got=%b%b%b%b exp=1111", PC_WRITE,
             IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH);
    end
    step(sub_x5, 1'b0, "fl_after", adv);
    step(idle, 1'b0, "fl_idle", adv);

    // Asynchronous reset in the middle of a stall
    do_reset("rst4");
    issue(add_x1, "ar_add");
    step(sub_x5, 1'b0, "ar_sub", adv);
    @(posedge CLOCK); #1;
    drive(sub_x5, 1'b0);
    #2 RESET = 1'b1;
    #1;
    n_assert++;
    assert (outs() === RST_OUT && STALL_COUNT === 16'd0) else begin
      n_fail++;
      $error("FAIL async_rst got=%b/%0d exp=%b/0", outs(), STALL_COUNT,
             RST_OUT);
    end
    @(posedge CLOCK); #1;
    drive(idle, 1'b0);
    RESET = 1'b0;
    model_reset();
    issue(sub_x5, "ar_resub");
    step(idle, 1'b0, "ar_idle", adv);
    n_assert++;
    assert (STALL_COUNT === 16'd0) else begin
      n_fail++;
      $error("FAIL async_rst_cnt got=%0d exp=0", STALL_COUNT);
    end

    // Random traffic over a small register set to provoke hazards
    do_reset("rst5");
    for (int i = 0; i < 600; i++) begin
      rin = mk($urandom_range(0, 4) != 0,
               regs[$urandom_range(0, 4)], $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0,
               regs[$urandom_range(0, 4)], $urandom_range(0, 3) != 0,
               regs[$urandom_range(0, 4)], $urandom_range(0, 1) != 0);
      step(rin, $urandom_range(0, 9) == 0, "rand", adv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller for the five-stage ARMv8 (LEGv8) core. It sits beside the instruction decoder in ID and keeps a shadow scoreboard of in-flight destination registers for EX, MEM and WB. From that scoreboard it drives PC/IF-ID write enables, ID/EX bubble insertion, branch flushes and, optionally, EX-stage forwarding selects. A multi-cycle stall state machine and a saturating stall counter make it the single sequencing authority for pipeline advance.

## Interface
- No parameters; register index width fixed at 5, XZR index fixed at 31.
- CLOCK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- ID_VALID  in  1  IF/ID holds a real instruction
- ID_RS1, ID_RS2  in  5  source registers of the ID instruction (Rn; Rm or Rt per Reg2Loc)
- ID_USES_RS1, ID_USES_RS2  in  1  source actually read
- ID_RD  in  5  destination register
- ID_REGWRITE, ID_MEMREAD  in  1  decoded RegWrite / MemRead of the ID instruction
- MEM_BRANCH_TAKEN  in  1  branch resolved taken in MEM
- PC_WRITE, IFID_WRITE  out  1  advance PC / IF-ID
- IDEX_BUBBLE  out  1  zero control fields entering ID/EX
- IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH  out  1  squash the stage register
- FWD_A, FWD_B  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- STALL_COUNT  out  16  total stall cycles, saturating

## Operation
- Shadow entry per stage (EX, MEM, WB): valid, rd, regwrite, memread, rs1, rs2, uses_rs1, uses_rs2.
- Entry is a producer only if valid, regwrite=1 and rd≠31. Source match requires uses_rsN=1, rsN≠31, rsN==rd.
- Register file is write-before-read: WB-stage matches never stall.
- Each clock: WB←MEM, MEM←EX, EX←ID fields (valid=ID_VALID) unless stalling or flushing, then EX←bubble (valid=0).
- Flush (MEM_BRANCH_TAKEN=1): IFID_FLUSH=IDEX_FLUSH=EXMEM_FLUSH=1, PC_WRITE=1, IFID_WRITE=1, IDEX_BUBBLE=0; next cycle EX←bubble, MEM←bubble, WB←old MEM.
- FSM states RUN, STALL; 2-bit counter CNT.
- RUN: if flush, take flush, stay RUN. Else if hazard needs N>0 cycles: stall now (PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1); if N=2, go STALL with CNT=1, else stay RUN.
- STALL: stall outputs asserted unconditionally; CNT decrements; at CNT=1 return to RUN. Flush in STALL overrides: flush outputs, CNT←0, RUN.
- STALL_COUNT increments on every cycle with IDEX_BUBBLE=1, holds at 16'hFFFF.
- Forwarding evaluated on the EX entry sources: EX/MEM (MEM entry) match → 10, else MEM/WB (WB entry) match → 01, else 00.

## Timing
- All control outputs are combinational from state, shadow entries and current inputs; same-cycle effect on PC and stage registers.
- Shadow entries, FSM, CNT and STALL_COUNT update on rising CLOCK.
- RESET high (asynchronous): RUN, CNT=0, all entries invalid, STALL_COUNT=0; outputs forced to PC_WRITE=1, IFID_WRITE=1, all flush/bubble 0, FWD_A=FWD_B=00, regardless of inputs. Reset mid-stall aborts the stall.
- Priority: RESET > flush > stall > advance.
- ID_VALID=0 never causes a stall.

## Configuration
- FORWARDING_EN defined: hazard only on load-use (EX entry memread=1 and matches an ID source) → N=1; FWD_A/FWD_B active as above.
- FORWARDING_EN undefined: FWD_A=FWD_B=00 permanently; match with EX entry → N=2, else match with MEM entry → N=1.

## Test plan
- LDUR X2 then ADD X3,X2,X4, FORWARDING_EN: one cycle PC_WRITE=0, IDEX_BUBBLE=1; next cycle FWD_A=01; STALL_COUNT=1.
- ADD X1 then SUB X5,X1,X1, FORWARDING_EN: no stall, FWD_A=FWD_B=10 when SUB in EX.
- Same ADD/SUB pair, no FORWARDING_EN: exactly 2 stall cycles (RUN→STALL→RUN), FWD stays 00, STALL_COUNT=2.
- Producer with ID_RD=31 followed by consumer of X31: no stall, FWD 00.
- MEM_BRANCH_TAKEN=1 during a 2-cycle STALL: all three flushes high that cycle, PC_WRITE=1, state RUN, EX/MEM entries invalid next cycle.
- RESET pulsed asynchronously mid-STALL: outputs immediately at reset values; after release first consumer of the old producer does not stall; STALL_COUNT=0.
